// File: rtl/char_buffer_scanout_pkg.sv
// rtl/char_buffer_scanout_pkg.sv - shared geometry and address layouts for the character buffer
// The {col, row} buffer packing and {code, line} font layout are shared with the buffer initialiser.
package char_buffer_scanout_pkg;

   localparam int MAXCOL            = 80;
   localparam int MAXROW            = 32;
   localparam int CHAR_W            = 8;
   localparam int CHAR_H            = 15;
   localparam int BLINK_FRAMES      = 30;
   localparam int CURSOR_START_LINE = 13;

   localparam int COL_W   = 7;
   localparam int ROW_W   = 5;
   localparam int PIX_W   = 3;
   localparam int LINE_W  = 4;
   localparam int CODE_W  = 7;
   localparam int BLINK_W = 5;
   localparam int ADDR_W  = COL_W + ROW_W;
   localparam int FONT_W  = CODE_W + LINE_W;

   function automatic logic [ADDR_W-1:0] char_addr(input logic [COL_W-1:0] col,
                                                   input logic [ROW_W-1:0] row);
      return {col, row};
   endfunction

   function automatic logic [FONT_W-1:0] font_addr(input logic [CODE_W-1:0] code,
                                                   input logic [LINE_W-1:0] line);
      return {code, line};
   endfunction

endpackage

// File: rtl/char_buffer_scanout_counters.sv
// rtl/char_buffer_scanout_counters.sv - raster position and cursor blink counters
// Priority frame_start > line_end > pixel_valid; the losing update is dropped.
module char_buffer_scanout_counters
   import char_buffer_scanout_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              line_end,
   input  logic              pixel_valid,
   output logic [PIX_W-1:0]  pix,
   output logic [COL_W-1:0]  char_col,
   output logic [LINE_W-1:0] scan_line,
   output logic [ROW_W-1:0]  char_row,
   output logic              blink_phase
);

   logic [BLINK_W-1:0] blink_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix         <= '0;
         char_col    <= '0;
         scan_line   <= '0;
         char_row    <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (frame_start) begin
         pix       <= '0;
         char_col  <= '0;
         scan_line <= '0;
         char_row  <= '0;
         if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end else if (line_end) begin
         pix      <= '0;
         char_col <= '0;
         if (scan_line == LINE_W'(CHAR_H - 1)) begin
            scan_line <= '0;
            char_row  <= (char_row == ROW_W'(MAXROW - 1)) ? '0 : char_row + 1'b1;
         end else begin
            scan_line <= scan_line + 1'b1;
         end
      end else if (pixel_valid) begin
         // Overscan pixels past the last column restart at column 0.
         if (pix == PIX_W'(CHAR_W - 1)) begin
            pix      <= '0;
            char_col <= (char_col == COL_W'(MAXCOL - 1)) ? '0 : char_col + 1'b1;
         end else begin
            pix <= pix + 1'b1;
         end
      end
   end

endmodule

// File: rtl/char_buffer_scanout.sv
// rtl/char_buffer_scanout.sv - raster scan of the character buffer into serial VGA pixels
// Three-stage pipeline: buffer read, font read, pixel select; cursor underline overlay.
module char_buffer_scanout
   import char_buffer_scanout_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              frameStart,
   input  logic              lineEnd,
   input  logic              pixelValid,
   input  logic              bufferBusy,
   input  logic              cursorEn,
   input  logic [ROW_W-1:0]  cursorRow,
   input  logic [COL_W-1:0]  cursorCol,
   output logic [ADDR_W-1:0] rdAddress,
   input  logic [CODE_W-1:0] rdData,
   output logic [FONT_W-1:0] fontAddress,
   input  logic [7:0]        fontData,
   output logic              pixelOut,
   output logic              pixelOutValid
);

   logic [PIX_W-1:0]  pix;
   logic [COL_W-1:0]  char_col;
   logic [LINE_W-1:0] scan_line;
   logic [ROW_W-1:0]  char_row;
   logic              blink_phase;
   logic              cursor_hit;

   logic              valid_s1, hit_s1, busy_s1;
   logic [PIX_W-1:0]  pix_s1;
   logic [LINE_W-1:0] line_s1;
   logic              valid_s2, hit_s2, busy_s2;
   logic [PIX_W-1:0]  pix_s2;

   char_buffer_scanout_counters u_counters (
      .clk         (clk),
      .rst         (reset),
      .frame_start (frameStart),
      .line_end    (lineEnd),
      .pixel_valid (pixelValid),
      .pix         (pix),
      .char_col    (char_col),
      .scan_line   (scan_line),
      .char_row    (char_row),
      .blink_phase (blink_phase)
   );

   assign rdAddress = char_addr(char_col, char_row);

   // Out-of-range cursor columns can never equal char_col, which stays below MAXCOL.
   assign cursor_hit = cursorEn & blink_phase & (cursorRow == char_row) &
                       (cursorCol == char_col) & (scan_line >= LINE_W'(CURSOR_START_LINE));

   assign fontAddress = font_addr(rdData, line_s1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_s1      <= 1'b0;
         hit_s1        <= 1'b0;
         busy_s1       <= 1'b0;
         pix_s1        <= '0;
         line_s1       <= '0;
         valid_s2      <= 1'b0;
         hit_s2        <= 1'b0;
         busy_s2       <= 1'b0;
         pix_s2        <= '0;
         pixelOut      <= 1'b0;
         pixelOutValid <= 1'b0;
      end else begin
         valid_s1      <= pixelValid;
         hit_s1        <= cursor_hit;
         busy_s1       <= bufferBusy;
         pix_s1        <= pix;
         line_s1       <= scan_line;
         valid_s2      <= valid_s1;
         hit_s2        <= hit_s1;
         busy_s2       <= busy_s1;
         pix_s2        <= pix_s1;
         pixelOut      <= valid_s2 & ~busy_s2 & (hit_s2 | fontData[3'd7 - pix_s2]);
         pixelOutValid <= valid_s2;
      end
   end

endmodule

// File: tb/tb_char_buffer_scanout.sv
// tb/tb_char_buffer_scanout.sv - self-checking bench for char_buffer_scanout
// Raster position is modelled as pixel/line/frame counts since the last frame or line start.
module tb_char_buffer_scanout;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frameStart = 1'b0, lineEnd = 1'b0, pixelValid = 1'b0;
   logic        bufferBusy = 1'b0, cursorEn = 1'b0;
   logic [4:0]  cursorRow = '0;
   logic [6:0]  cursorCol = '0;
   logic [11:0] rdAddress;
   logic [6:0]  rdData = '0;
   logic [10:0] fontAddress;
   logic [7:0]  fontData = '0;
   logic        pixelOut, pixelOutValid;

   logic [6:0]  charmem [0:4095];
   logic [7:0]  fontmem [0:2047];

   int checks = 0, errors = 0;
   int px = 0, ln = 0, f = 0;
   int ones = 0;
   logic [1:0]  h0 = '0, h1 = '0, h2 = '0;
   logic        prev_pv = 1'b0;
   logic [10:0] prev_fa = '0;
   logic [7:0]  obs_hist = '0;

   always #5 clk = ~clk;

   char_buffer_scanout dut (
      .clk           (clk),
      .reset         (reset),
      .frameStart    (frameStart),
      .lineEnd       (lineEnd),
      .pixelValid    (pixelValid),
      .bufferBusy    (bufferBusy),
      .cursorEn      (cursorEn),
      .cursorRow     (cursorRow),
      .cursorCol     (cursorCol),
      .rdAddress     (rdAddress),
      .rdData        (rdData),
      .fontAddress   (fontAddress),
      .fontData      (fontData),
      .pixelOut      (pixelOut),
      .pixelOutValid (pixelOutValid)
   );

   always @(posedge clk) begin
      rdData   <= charmem[rdAddress];
      fontData <= fontmem[fontAddress];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic fs, input logic le, input logic pv);
      int col, pix, sl, row;
      logic phase, hit, pxl;
      logic [11:0] addr;
      frameStart = fs; lineEnd = le; pixelValid = pv;
      col   = (px / 8) % 80;
      pix   = px % 8;
      sl    = ln % 15;
      row   = (ln / 15) % 32;
      phase = ((f / 30) % 2) == 0;
      addr  = 12'(col * 32 + row);
      chk("rdAddress", rdAddress, addr);
      if (prev_pv) chk("fontAddress", fontAddress, prev_fa);
      hit = cursorEn && phase && (cursorRow == row) && (cursorCol == col) && (sl >= 13);
      pxl = pv && !bufferBusy && (hit || fontmem[11'(charmem[addr] * 16 + sl)][7 - pix]);
      h2 = h1; h1 = h0; h0 = {pv, pxl};
      prev_pv = pv;
      prev_fa = {charmem[addr], 4'(sl)};
      if (fs) begin px = 0; ln = 0; f++; end
      else if (le) begin px = 0; ln++; end
      else if (pv) px++;
      @(posedge clk); #1;
      frameStart = 1'b0; lineEnd = 1'b0; pixelValid = 1'b0;
      chk("pixelOutValid", pixelOutValid, h2[1]);
      chk("pixelOut", pixelOut, h2[0]);
      if (pixelOutValid) begin
         obs_hist = {obs_hist[6:0], pixelOut};
         if (pixelOut) ones++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      chk("rst_pixelOut", pixelOut, 0);
      chk("rst_pixelOutValid", pixelOutValid, 0);
      chk("rst_rdAddress", rdAddress, 0);
      @(posedge clk); #1 reset = 1'b0;
      px = 0; ln = 0; f = 0;
      h0 = '0; h1 = '0; h2 = '0;
      prev_pv = 1'b0;
   endtask

   task automatic cursor_frame();
      cyc(1'b1, 1'b0, 1'b0);
      repeat (90) begin
         repeat (88) cyc(1'b0, 1'b0, 1'b1);
         cyc(1'b0, 1'b1, 1'b0);
      end
      idle(2);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) charmem[i] = 7'($urandom);
      for (int i = 0; i < 2048; i++) fontmem[i] = 8'($urandom);
      @(posedge clk); #1;
      do_reset();

      // reset in the middle of a line, then the first pixel of a frame
      cyc(1'b1, 1'b0, 1'b0);
      repeat (37) cyc(1'b0, 1'b0, 1'b1);
      charmem[0] = 7'h41;
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      chk("first_rdAddress", rdAddress, 12'h000);
      cyc(1'b0, 1'b0, 1'b1);
      chk("first_fontAddress", fontAddress, 11'h410);
      idle(2);
      chk("first_valid", pixelOutValid, 1);
      chk("first_pixel", pixelOut, fontmem[11'h410][7]);

      // single cell with a known font row
      charmem[0] = 7'h55;
      fontmem[11'h550] = 8'hA0;
      cyc(1'b1, 1'b0, 1'b0);
      obs_hist = '0;
      repeat (8) cyc(1'b0, 1'b0, 1'b1);
      idle(3);
      chk("cell_pattern", obs_hist, 8'hA0);

      // full frame: first and last lines at full width, the rest short
      cyc(1'b1, 1'b0, 1'b0);
      for (int l = 0; l < 480; l++) begin
         for (int i = 0; i < ((l == 0 || l == 479) ? 640 : 16); i++) begin
            if (l == 479 && i == 639) chk("last_address", rdAddress, {7'd79, 5'd31});
            cyc(1'b0, 1'b0, 1'b1);
         end
         cyc(1'b0, 1'b1, 1'b0);
      end
      chk("frame_end_address", rdAddress, 12'h000);
      cyc(1'b1, 1'b0, 1'b0);
      chk("frame_restart_address", rdAddress, 12'h000);

      // cursor underline and blink with a blank font
      for (int i = 0; i < 2048; i++) fontmem[i] = 8'h00;
      do_reset();
      cursorEn = 1'b1; cursorRow = 5'd5; cursorCol = 7'd10;
      ones = 0;
      cursor_frame();
      chk("cursor_on", ones, 16);
      repeat (29) cyc(1'b1, 1'b0, 1'b0);
      ones = 0;
      cursor_frame();
      chk("cursor_blink_off", ones, 0);
      repeat (29) cyc(1'b1, 1'b0, 1'b0);
      ones = 0;
      cursor_frame();
      chk("cursor_on_again", ones, 16);
      cursorEn = 1'b0;
      for (int i = 0; i < 2048; i++) fontmem[i] = 8'($urandom);

      // all three strobes together
      cyc(1'b1, 1'b0, 1'b0);
      repeat (20) cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
      chk("simul_rdAddress", rdAddress, 12'h000);
      idle(2);
      chk("simul_valid", pixelOutValid, 1);

      // buffer busy blanks a solid cell
      charmem[0] = 7'h7F;
      fontmem[11'h7F0] = 8'hFF;
      cyc(1'b1, 1'b0, 1'b0);
      bufferBusy = 1'b1;
      ones = 0;
      repeat (8) cyc(1'b0, 1'b0, 1'b1);
      idle(2);
      chk("busy_blank", ones, 0);
      bufferBusy = 1'b0;

      // overscan past the last column
      cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 700; i++) begin
         if (i == 640) chk("overscan_wrap", rdAddress, 12'h000);
         chk("rdAddress_known", $isunknown(rdAddress), 0);
         cyc(1'b0, 1'b0, 1'b1);
      end
      cyc(1'b0, 1'b1, 1'b0);

      // random traffic
      cursorEn = 1'b1; cursorRow = 5'd0; cursorCol = 7'd3;
      repeat (4000) begin
         if ($urandom % 50 == 0) bufferBusy = ~bufferBusy;
         if ($urandom % 200 == 0) begin
            cursorEn  = ($urandom % 4) != 0;
            cursorRow = 5'($urandom_range(0, 1));
            cursorCol = ($urandom % 5 == 0) ? 7'($urandom_range(80, 127)) : 7'($urandom_range(0, 11));
         end
         cyc($urandom % 1500 == 0, $urandom % 90 == 0, $urandom % 4 != 0);
      end
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/char_buffer_scanout.md
Name: char_buffer_scanout

Overview:
Read-side counterpart of the character-buffer initialiser. It scans the 80x32 character buffer in raster order for VGA display and forms read addresses in the same {col[6:0], row[4:0]} layout the writer uses. Each character code is turned into a font-ROM lookup, and one serial pixel is emitted per active-video pixel, with a blinking cursor overlay. It sits between the VGA timing generator, the character buffer read port and the font ROM.

Parameters:
MAXCOL, 80, characters per row; column index 0..MAXCOL-1
MAXROW, 32, character rows; row index 0..MAXROW-1
CHAR_W, 8, pixels per character cell (font byte width)
CHAR_H, 15, scan lines per character cell (480/32)
BLINK_FRAMES, 30, frames per cursor blink phase
CURSOR_START_LINE, 13, first scan line of the underline cursor

Ports:
clk  in  1  system clock, single domain
reset  in  1  asynchronous, active-high reset
frameStart  in  1  one-cycle pulse at start of frame (before first active line)
lineEnd  in  1  one-cycle pulse after the last active pixel of a line
pixelValid  in  1  active-video pixel strobe, one per pixel
bufferBusy  in  1  initialiser writing; blank the display
cursorEn  in  1  cursor display enable
cursorRow  in  5  cursor row
cursorCol  in  7  cursor column
rdAddress  out  12  char buffer read address {charCol, charRow}, combinational from counters
rdData  in  7  char code, valid 1 cycle after rdAddress
fontAddress  out  11  {rdData[6:0], scanLine_s1[3:0]}, combinational
fontData  in  8  font row, valid 1 cycle after fontAddress; bit 7 = leftmost pixel
pixelOut  out  1  registered video pixel
pixelOutValid  out  1  registered, aligned with pixelOut

Behaviour:
- Reset (async, immediate): all counters 0, blink counter 0, blinkPhase 1, pipeline valids 0, pixelOut 0, pixelOutValid 0.
- Counters: pix (0..CHAR_W-1), charCol (7b), scanLine (4b, 0..CHAR_H-1), charRow (5b).
- pixelValid: pix+1; at pix==CHAR_W-1, pix=0 and charCol+1. If charCol==MAXCOL-1 at that point, charCol wraps to 0 (overscan lines repeat from column 0).
- lineEnd: pix=0, charCol=0, scanLine+1. At scanLine==CHAR_H-1, scanLine=0 and charRow+1. charRow wraps MAXROW-1 -> 0.
- frameStart: pix, charCol, scanLine and charRow all set to 0. Blink counter +1; at BLINK_FRAMES-1 it wraps to 0 and blinkPhase toggles.
- Priority in the same cycle: frameStart > lineEnd > pixelValid. The lower-priority counter update is dropped. A pixelValid dropped this way still enters the pipeline.
- Pipeline, 3-cycle latency; pixelValid at cycle N -> pixelOutValid at N+3.
  - S1 (N+1) registers: valid, pix, scanLine, cursorHit, busy.
  - cursorHit = cursorEn & blinkPhase & charRow==cursorRow & charCol==cursorCol & scanLine>=CURSOR_START_LINE, evaluated at cycle N.
  - S2 (N+2) registers S1 fields. fontAddress is driven during S1 from rdData.
  - S3 (N+3): pixelOut = busy_s2 ? 0 : (cursorHit_s2 | fontData[7-pix_s2]); pixelOutValid = valid_s2.
- When pixelOutValid is 0, pixelOut is 0.
- No stalls. Back-to-back pixelValid is supported at full rate.
- Cursor values outside range (row>=MAXROW, col>=MAXCOL) never match.
- bufferBusy toggling mid-line affects only pixels sampled while it is high.

Decomposition:
- Shared vgaminikbd package/header holds MAXCOL, MAXROW, CHAR_W, CHAR_H, the address packing order {col, row} and the font address layout. The packing order and font layout are shared with charBufferInit.
- One sub-module: scanout_counters, covering pix/col/scanLine/row and blink with the stated priority.
- The 3-stage pipeline stays in the top module.

Test Plan:
- Reset mid-line, then frameStart and one pixelValid -> rdAddress=12'h000. With rdData=7'h41 the bench checks fontAddress=11'h410 at N+1, and pixelOutValid=1 with pixelOut=fontData[7] at N+3.
- 640 pixelValid then lineEnd, repeated for 480 lines -> rdAddress steps col 0..79 every 8 pixels. Row advances every 15 lines, the last address seen is {7'd79, 5'd31}, and the next frameStart returns to 0.
- fontData=8'b1010_0000 held for one cell -> pixelOut sequence 1,0,1,0,0,0,0,0, each 3 cycles after its strobe.
- cursorEn=1, cursor (5,10), fontData=0 -> pixelOut=1 only for scan lines 13..14 of cell row 5, col 10. After 30 frameStarts the cursor is absent, and it returns after 30 more.
- frameStart, lineEnd and pixelValid asserted in the same cycle -> counters all 0 and pixelOutValid still asserted at N+3. Separately, bufferBusy=1 with fontData=8'hFF -> pixelOut=0.
- 700 pixelValid on one line -> charCol wraps to 0 after column 79, with no X on rdAddress.
